// File: rtl/block_chain_pkg.sv
// rtl/block_chain_pkg.sv - shared types, header layout and mask helpers for block_chain_framer
package block_chain_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam int MAX_CH   = 8;
  localparam int HDR_ID_W = 4;

  // Chain word: sample plus a valid flag in the MSB.
  function automatic int word_w(input int bits_adc);
    return bits_adc + 1;
  endfunction

  // Header: {valid, id, zero pad, mask}; id sits directly under the valid bit.
  function automatic int hdr_id_lsb(input int bits_adc);
    return bits_adc - HDR_ID_W;
  endfunction

  function automatic int hdr_mask_lsb();
    return 0;
  endfunction

  function automatic logic [3:0] popcount(input logic [MAX_CH-1:0] m);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      n = n + {3'b000, m[i]};
    end
    return n;
  endfunction

  function automatic logic [2:0] lowest_set(input logic [MAX_CH-1:0] m);
    logic [2:0] idx;
    idx = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/chain_fifo.sv
// rtl/chain_fifo.sv - synchronous FIFO for upstream chain words
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module chain_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("chain_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/block_chain_framer.sv
// rtl/block_chain_framer.sv - captures NUM_CH ADC samples per data-ready edge and merges them onto the daisy chain
// Optional header word before each burst when BLOCK_CHAIN_HDR_EN is defined.
module block_chain_framer
  import block_chain_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int BITS_ADC   = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int BLOCK_ID   = 0
) (
  input  logic                         clk_3p2M,
  input  logic                         rst,
  input  logic                         adc_ready,
  input  logic [NUM_CH*BITS_ADC-1:0]   data_from_adc,
  input  logic [NUM_CH-1:0]            ch_en,
  input  logic [BITS_ADC:0]            data_from_pre,
  output logic [BITS_ADC:0]            data_to_post,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         ovf_fifo,
  output logic                         ovf_samp,
  input  logic                         clr_ovf
);

  localparam int W = word_w(BITS_ADC);

  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_ch
    $error("block_chain_framer: NUM_CH must be 1..8");
  end
  if (BLOCK_ID < 0 || BLOCK_ID > 15) begin : g_bad_id
    $error("block_chain_framer: BLOCK_ID must fit in 4 bits");
  end
`ifdef BLOCK_CHAIN_HDR_EN
  if (HDR_ID_W + NUM_CH > BITS_ADC) begin : g_bad_hdr
    $error("block_chain_framer: header needs 4+NUM_CH <= BITS_ADC");
  end
`endif

  function automatic logic [BITS_ADC-1:0] pick(input logic [NUM_CH*BITS_ADC-1:0] v,
                                               input logic [2:0] idx);
    logic [BITS_ADC-1:0] s;
    s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (idx == 3'(c)) s = v[c*BITS_ADC +: BITS_ADC];
    end
    return s;
  endfunction

  state_t                     state, state_n;
  logic                       adc_prev;
  logic                       capture;
  logic [NUM_CH*BITS_ADC-1:0] samp_q;
  logic [NUM_CH-1:0]          pend, pend_n;
  logic [3:0]                 left, left_n;
  logic [MAX_CH-1:0]          en_ext, pend_ext;
  logic [W-1:0]               dout_n;
  logic                       local_word;
  logic                       fifo_pop;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [W-1:0]               fifo_rdata;
  logic                       fifo_push;

  assign capture   = adc_ready && !adc_prev;
  assign busy      = (state != IDLE);
  assign fifo_push = data_from_pre[W-1];

`ifdef BLOCK_CHAIN_HDR_EN
  logic [W-1:0] hdr_word;
  always_comb begin
    hdr_word = '0;
    hdr_word[W-1] = 1'b1;
    hdr_word[hdr_id_lsb(BITS_ADC) +: HDR_ID_W] = 4'(BLOCK_ID);
    hdr_word[hdr_mask_lsb() +: NUM_CH] = ch_en;
  end
`endif

  // pend holds channels still to send; left counts the words after the current one.
  always_comb begin
    state_n    = state;
    pend_n     = pend;
    left_n     = left;
    dout_n     = '0;
    fifo_pop   = 1'b0;
    local_word = 1'b0;
    en_ext     = '0;
    en_ext[NUM_CH-1:0] = ch_en;
    pend_ext   = '0;
    pend_ext[NUM_CH-1:0] = pend;
    if (state == IDLE) begin
      if (capture && (ch_en != '0)) begin
        local_word = 1'b1;
`ifdef BLOCK_CHAIN_HDR_EN
        state_n = HDR;
        dout_n  = hdr_word;
        pend_n  = ch_en;
        left_n  = popcount(en_ext);
`else
        state_n = SEND;
        dout_n  = {1'b1, pick(data_from_adc, lowest_set(en_ext))};
        pend_n  = ch_en & (ch_en - NUM_CH'(1));
        left_n  = popcount(en_ext) - 4'd1;
`endif
      end
    end else if (left != '0) begin
      local_word = 1'b1;
      state_n    = SEND;
      dout_n     = {1'b1, pick(samp_q, lowest_set(pend_ext))};
      pend_n     = pend & (pend - NUM_CH'(1));
      left_n     = left - 4'd1;
    end else begin
      state_n = IDLE;
    end
    // Upstream traffic fills every cycle not claimed by a local word.
    if (!local_word && !fifo_empty) begin
      fifo_pop = 1'b1;
      dout_n   = fifo_rdata;
    end
  end

  always_ff @(posedge clk_3p2M) begin
    if (rst) begin
      state        <= IDLE;
      adc_prev     <= 1'b1;
      samp_q       <= '0;
      pend         <= '0;
      left         <= '0;
      data_to_post <= '0;
      ovf_samp     <= 1'b0;
      ovf_fifo     <= 1'b0;
    end else begin
      state        <= state_n;
      adc_prev     <= adc_ready;
      pend         <= pend_n;
      left         <= left_n;
      data_to_post <= dout_n;
      if (capture && state == IDLE) samp_q <= data_from_adc;
      if (capture && busy)          ovf_samp <= 1'b1;
      else if (clr_ovf)             ovf_samp <= 1'b0;
      if (fifo_push && fifo_full && !fifo_pop) ovf_fifo <= 1'b1;
      else if (clr_ovf)                        ovf_fifo <= 1'b0;
    end
  end

  chain_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_3p2M),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (data_from_pre),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_block_chain_framer.sv
// tb/tb_block_chain_framer.sv - table plus scoreboard bench for block_chain_framer
module tb_block_chain_framer;

  localparam int BLOCK_ID = 5;

  logic        clk_3p2M = 1'b0;
  logic        rst;
  logic        adc_ready;
  logic [47:0] data_from_adc;
  logic [3:0]  ch_en;
  logic [12:0] data_from_pre;
  logic [12:0] data_to_post;
  logic        busy;
  logic [3:0]  fifo_level;
  logic        ovf_fifo;
  logic        ovf_samp;
  logic        clr_ovf;

  always #5 clk_3p2M = ~clk_3p2M;

  block_chain_framer #(
    .NUM_CH     (4),
    .BITS_ADC   (12),
    .FIFO_DEPTH (8),
    .BLOCK_ID   (BLOCK_ID)
  ) dut (
    .clk_3p2M      (clk_3p2M),
    .rst           (rst),
    .adc_ready     (adc_ready),
    .data_from_adc (data_from_adc),
    .ch_en         (ch_en),
    .data_from_pre (data_from_pre),
    .data_to_post  (data_to_post),
    .busy          (busy),
    .fifo_level    (fifo_level),
    .ovf_fifo      (ovf_fifo),
    .ovf_samp      (ovf_samp),
    .clr_ovf       (clr_ovf)
  );

  int cyc = 0;
  always @(posedge clk_3p2M) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    int          at;
    logic [12:0] word;
    logic        bsy;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  bit   mon_en = 1'b0;

  function automatic void sb_add(input int at, input logic [12:0] w, input logic b);
    exp_t e;
    int i;
    e.at = at; e.word = w; e.bsy = b;
    i = 0;
    while (i < sb.size() && sb[i].at <= at) i++;
    sb.insert(i, e);
  endfunction

  always @(negedge clk_3p2M) begin
    if (mon_en) begin
      while (sb.size() > 0 && sb[0].at < cyc) begin
        mon_e = sb.pop_front();
        n_chk++;
        $display("FAIL sb_missed@%0d: word %h never checked", mon_e.at, mon_e.word);
      end
      if (sb.size() > 0 && sb[0].at == cyc) begin
        mon_e = sb.pop_front();
        chk($sformatf("word@%0d", cyc), 32'(data_to_post), 32'(mon_e.word));
        chk($sformatf("busy@%0d", cyc), 32'(busy), 32'(mon_e.bsy));
      end else begin
        chk($sformatf("idle_word@%0d", cyc), 32'(data_to_post), 32'h0);
        chk($sformatf("idle_busy@%0d", cyc), 32'(busy), 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk_3p2M);
    #1;
  endtask

  // Rising edge on adc_ready in cycle t; inputs are scrambled in t+1 to prove they were latched.
  task automatic fire(input logic [3:0] mask, input logic [47:0] samp, output int t);
    tick();
    t = cyc;
    adc_ready = 1'b1; ch_en = mask; data_from_adc = samp;
    tick();
    adc_ready = 1'b0; ch_en = ~mask; data_from_adc = ~samp;
  endtask

  task automatic expect_burst(input int t, input logic [3:0] mask, input int n,
                              input logic [3:0][12:0] w);
    int k;
    k = 0;
`ifdef BLOCK_CHAIN_HDR_EN
    sb_add(t + 1, 13'h1000 | (13'(BLOCK_ID) << 8) | 13'(mask), 1'b1);
    k = 1;
`endif
    for (int i = 0; i < n; i++) sb_add(t + 1 + k + i, w[i], 1'b1);
  endtask

  typedef struct {
    logic [3:0]       mask;
    logic [47:0]      samp;
    int               n;
    logic [3:0][12:0] w;
  } vec_t;

  vec_t vt[5];

  initial begin
    int t;
    int c0;
    vt[0] = '{4'b1011, 48'h444_333_222_111, 3, {13'h0000, 13'h1444, 13'h1222, 13'h1111}};
    vt[1] = '{4'b0001, 48'h000_000_000_5A5, 1, {13'h0000, 13'h0000, 13'h0000, 13'h15A5}};
    vt[2] = '{4'b1000, 48'hFFF_0AB_0CD_0EF, 1, {13'h0000, 13'h0000, 13'h0000, 13'h1FFF}};
    vt[3] = '{4'b1111, 48'h7FF_800_001_000, 4, {13'h17FF, 13'h1800, 13'h1001, 13'h1000}};
    vt[4] = '{4'b0110, 48'h456_123_DEF_ABC, 2, {13'h0000, 13'h0000, 13'h1123, 13'h1DEF}};

    rst = 1'b1; adc_ready = 1'b1; ch_en = 4'hF; data_from_adc = 48'h123_456_789_ABC;
    data_from_pre = 13'h0; clr_ovf = 1'b0;
    repeat (3) tick();
    @(negedge clk_3p2M);
    chk("rst_data", 32'(data_to_post), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_level", 32'(fifo_level), 32'h0);
    chk("rst_ovf_fifo", 32'(ovf_fifo), 32'h0);
    chk("rst_ovf_samp", 32'(ovf_samp), 32'h0);

    // Release reset with adc_ready held high: must not capture.
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (4) tick();
    adc_ready = 1'b0;

    foreach (vt[i]) begin
      fire(vt[i].mask, vt[i].samp, t);
      expect_burst(t, vt[i].mask, vt[i].n, vt[i].w);
      repeat (5) tick();
    end

    // Edge during a burst is ignored and flagged; clr_ovf clears it.
    fire(vt[0].mask, vt[0].samp, t);
    expect_burst(t, vt[0].mask, vt[0].n, vt[0].w);
    tick();
    adc_ready = 1'b1; ch_en = 4'b0101; data_from_adc = 48'h999_888_777_666;
    tick();
    adc_ready = 1'b0;
    @(negedge clk_3p2M);
    chk("ovf_samp_set", 32'(ovf_samp), 32'h1);
    repeat (3) tick();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    @(negedge clk_3p2M);
    chk("ovf_samp_cleared", 32'(ovf_samp), 32'h0);
    chk("ovf_fifo_quiet", 32'(ovf_fifo), 32'h0);

    // clr_ovf coinciding with a new ignored edge leaves the flag set.
    fire(vt[3].mask, vt[3].samp, t);
    expect_burst(t, vt[3].mask, vt[3].n, vt[3].w);
    tick();
    adc_ready = 1'b1; clr_ovf = 1'b1;
    tick();
    adc_ready = 1'b0; clr_ovf = 1'b0;
    @(negedge clk_3p2M);
    chk("ovf_samp_clr_vs_set", 32'(ovf_samp), 32'h1);
    repeat (4) tick();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;

`ifndef BLOCK_CHAIN_HDR_EN
    // Three back-to-back bursts with 12 upstream words: FIFO fills, w10/w11 dropped.
    tick();
    c0 = cyc;
    for (int k = 0; k < 3; k++) begin
      sb_add(c0 + 5*k + 1, 13'h10AA, 1'b1);
      sb_add(c0 + 5*k + 2, 13'h10BB, 1'b1);
      sb_add(c0 + 5*k + 3, 13'h10CC, 1'b1);
      sb_add(c0 + 5*k + 4, 13'h10DD, 1'b1);
    end
    sb_add(c0 + 5,  13'h1AA0, 1'b0);
    sb_add(c0 + 10, 13'h1AA1, 1'b0);
    for (int j = 2; j < 10; j++) sb_add(c0 + 13 + j, 13'h1AA0 + 13'(j), 1'b0);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      data_from_pre = 13'h1AA0 + 13'(i);
      adc_ready     = (i == 0 || i == 5 || i == 10);
      ch_en         = 4'hF;
      data_from_adc = 48'h0DD_0CC_0BB_0AA;
      if (i == 9) begin
        @(negedge clk_3p2M);
        chk("fifo_full_level", 32'(fifo_level), 32'd8);
      end
      if (i == 10) begin
        @(negedge clk_3p2M);
        chk("ovf_fifo_before_drop", 32'(ovf_fifo), 32'h0);
      end
      if (i == 11) begin
        @(negedge clk_3p2M);
        chk("ovf_fifo_after_drop", 32'(ovf_fifo), 32'h1);
      end
    end
    tick();
    data_from_pre = 13'h0; adc_ready = 1'b0;
    while (cyc < c0 + 24) tick();
    @(negedge clk_3p2M);
    chk("fifo_drained", 32'(fifo_level), 32'h0);
    chk("ovf_fifo_sticky", 32'(ovf_fifo), 32'h1);
    tick();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
`endif

    // Empty mask edge: nothing local; upstream passes with 2-cycle latency, invalid words dropped.
    tick();
    t = cyc;
    adc_ready = 1'b1; ch_en = 4'b0000; data_from_pre = 13'h1BCD;
    sb_add(t + 2, 13'h1BCD, 1'b0);
    tick();
    adc_ready = 1'b0; data_from_pre = 13'h0ACE;
    tick();
    data_from_pre = 13'h1765;
    sb_add(t + 4, 13'h1765, 1'b0);
    tick();
    data_from_pre = 13'h0;
    repeat (4) tick();
    @(negedge clk_3p2M);
    chk("zero_mask_ovf_samp", 32'(ovf_samp), 32'h0);
    chk("end_level", 32'(fifo_level), 32'h0);
    chk("end_ovf_fifo", 32'(ovf_fifo), 32'h0);

    repeat (2) tick();
    mon_en = 1'b0;
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
